// File: rtl/prim_intr_hw_coalesce.sv
// prim_intr_hw_coalesce
// Per-peripheral interrupt handler with an interrupt-moderation stage.
// Each source is either Event type (latched into INTR_STATE by the CSR block,
// optionally rising-edge detected) or Status type (INTR_STATE mirrors the live
// input OR'd with a sticky test value). Enabled, pending sources drive the
// flopped per-bit intr_o. The aggregate irq_o either follows "any pending"
// directly, or, with moderation enabled, fires once enough new pending bits
// have arrived or a timeout has elapsed since the first arrival.
module prim_intr_hw_coalesce #(
   parameter int              Width      = 8,
   parameter logic [Width-1:0] StatusMask = '0,
   parameter logic [Width-1:0] EdgeMask   = '0,
   parameter int              CntW       = 8,
   parameter int              TimerW     = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [Width-1:0]  event_intr_i,
   input  logic [Width-1:0]  reg2hw_intr_enable_q_i,
   input  logic [Width-1:0]  reg2hw_intr_test_q_i,
   input  logic              reg2hw_intr_test_qe_i,
   input  logic [Width-1:0]  reg2hw_intr_state_q_i,
   output logic [Width-1:0]  hw2reg_intr_state_de_o,
   output logic [Width-1:0]  hw2reg_intr_state_d_o,
   input  logic              cfg_coal_en_i,
   input  logic [CntW-1:0]   cfg_thresh_i,
   input  logic [TimerW-1:0] cfg_timeout_i,
   output logic [Width-1:0]  intr_o,
   output logic              irq_o,
   output logic [CntW-1:0]   coal_cnt_o
);

   // Popcount of Width bits needs enough room to hold Width itself.
   localparam int ArrW = $clog2(Width + 1);
   // Sum width wide enough that cnt + arr never wraps before saturation.
   localparam int SumW = ((CntW > ArrW) ? CntW : ArrW) + 1;

   localparam logic [CntW-1:0]   CntMax = '1;
   localparam logic [TimerW-1:0] TmrMax = '1;

   // Edge detection only applies to Event-type sources.
   localparam logic [Width-1:0] EdgeOnly = EdgeMask & ~StatusMask;

   typedef enum logic [1:0] {
      IdleSt,
      WaitSt,
      FireSt
   } coal_state_e;

   // Registered state
   logic [Width-1:0]  ev_q, ev_d;
   logic [Width-1:0]  test_status_q, test_status_d;
   logic [Width-1:0]  intr_q, intr_d;
   logic [Width-1:0]  prev_q, prev_d;
   logic              irq_q, irq_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [TimerW-1:0] tmr_q, tmr_d;
   coal_state_e       fsm_q, fsm_d;

   // Combinational intermediates
   logic [Width-1:0]  test_vec;
   logic [Width-1:0]  ev_det;
   logic [Width-1:0]  status_src;
   logic [Width-1:0]  status;
   logic [Width-1:0]  state_de;
   logic [Width-1:0]  state_d;
   logic [Width-1:0]  status_en;
   logic [Width-1:0]  arr_bits;
   logic              pend;
   logic [ArrW-1:0]   arr_cnt;
   logic [SumW-1:0]   cnt_sum;
   logic [CntW-1:0]   cnt_sat;
   logic [CntW-1:0]   arr_sat;
   logic [TimerW-1:0] tmr_inc;
   logic              cnt_fire;
   logic              tmr_fire;

   // Source conditioning: edge detect, test injection and INTR_STATE update.
   // Event bits only request a write when something new happens and always
   // write a 1; Status bits rewrite INTR_STATE every cycle with the live value.
   always_comb begin
      test_vec      = {Width{reg2hw_intr_test_qe_i}} & reg2hw_intr_test_q_i;
      ev_det        = event_intr_i & ~(ev_q & EdgeOnly);
      status_src    = event_intr_i | test_status_q;
      status        = (StatusMask & status_src) | (~StatusMask & reg2hw_intr_state_q_i);
      state_de      = StatusMask | test_vec | ev_det;
      state_d       = (StatusMask & status_src) | ~StatusMask;
      ev_d          = event_intr_i;
      test_status_d = reg2hw_intr_test_qe_i ? (reg2hw_intr_test_q_i & StatusMask)
                                            : test_status_q;
   end

   // Pending view of enabled sources and the set of bits that just became pending.
   always_comb begin
      status_en = status & reg2hw_intr_enable_q_i;
      pend      = |status_en;
      arr_bits  = status_en & ~prev_q;
      intr_d    = status_en;
      prev_d    = status_en;
   end

   // Count how many sources became newly pending this cycle.
   always_comb begin
      arr_cnt = '0;
      for (int i = 0; i < Width; i++) begin
         arr_cnt = arr_cnt + ArrW'(arr_bits[i]);
      end
   end

   // Saturating next values for the arrival counter and timer, and the two
   // fire conditions evaluated against the current configuration.
   always_comb begin
      cnt_sum  = SumW'(cnt_q) + SumW'(arr_cnt);
      cnt_sat  = (cnt_sum > SumW'(CntMax)) ? CntMax : CntW'(cnt_sum);
      arr_sat  = (SumW'(arr_cnt) > SumW'(CntMax)) ? CntMax : CntW'(arr_cnt);
      tmr_inc  = (tmr_q == TmrMax) ? tmr_q : tmr_q + TimerW'(1);
      cnt_fire = (cnt_sat >= cfg_thresh_i);
      tmr_fire = (cfg_timeout_i != '0) && (tmr_inc >= cfg_timeout_i);
   end

   // Moderation FSM: IDLE waits for a first arrival, WAIT accumulates arrivals
   // and time until a fire condition, FIRE holds irq until software clears all
   // pending bits. Disabling moderation forces IDLE with cleared counters.
   always_comb begin
      fsm_d = fsm_q;
      cnt_d = cnt_q;
      tmr_d = tmr_q;
      if (!cfg_coal_en_i) begin
         fsm_d = IdleSt;
         cnt_d = '0;
         tmr_d = '0;
      end else begin
         case (fsm_q)
            IdleSt: begin
               if (arr_cnt != '0) begin
                  cnt_d = arr_sat;
                  tmr_d = TimerW'(1);
                  fsm_d = (arr_sat >= cfg_thresh_i) ? FireSt : WaitSt;
               end
            end
            WaitSt: begin
               if (cnt_fire || tmr_fire) begin
                  fsm_d = FireSt;
                  cnt_d = cnt_sat;
                  tmr_d = tmr_inc;
               end else if (!pend) begin
                  fsm_d = IdleSt;
                  cnt_d = '0;
                  tmr_d = '0;
               end else begin
                  cnt_d = cnt_sat;
                  tmr_d = tmr_inc;
               end
            end
            FireSt: begin
               if (!pend) begin
                  fsm_d = IdleSt;
                  cnt_d = '0;
                  tmr_d = '0;
               end
            end
            default: begin
               fsm_d = IdleSt;
               cnt_d = '0;
               tmr_d = '0;
            end
         endcase
      end
   end

   // Aggregate irq: raw pending when unmoderated, otherwise the FIRE state.
   always_comb begin
      irq_d = cfg_coal_en_i ? (fsm_d == FireSt) : pend;
   end

   // All state flops, cleared asynchronously so no irq pulse follows reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ev_q          <= '0;
         test_status_q <= '0;
         intr_q        <= '0;
         prev_q        <= '0;
         irq_q         <= 1'b0;
         cnt_q         <= '0;
         tmr_q         <= '0;
         fsm_q         <= IdleSt;
      end else begin
         ev_q          <= ev_d;
         test_status_q <= test_status_d;
         intr_q        <= intr_d;
         prev_q        <= prev_d;
         irq_q         <= irq_d;
         cnt_q         <= cnt_d;
         tmr_q         <= tmr_d;
         fsm_q         <= fsm_d;
      end
   end

   assign hw2reg_intr_state_de_o = state_de;
   assign hw2reg_intr_state_d_o  = state_d;
   assign intr_o                 = intr_q;
   assign irq_o                  = irq_q;
   assign coal_cnt_o             = cnt_q;

endmodule

// File: doc/prim_intr_hw_coalesce.md
Name: prim_intr_hw_coalesce

Overview:
- Generalised per-peripheral interrupt handler for a vector of Width interrupt sources.
- Each bit is independently Event or Status type. Event inputs can optionally be rising-edge detected.
- Interrupt-moderation (coalescing) stage: the aggregated IRQ line fires after N new pending interrupts or after a timeout since the first one, whichever comes first.
- Sits between peripheral event logic and the generated INTR_STATE/ENABLE/TEST CSRs; drives per-bit intr_o and one moderated irq_o to the PLIC.

Parameters:
- Width, 8: number of interrupt sources.
- StatusMask, '0 (Width bits): bit i = 1 makes source i Status type; 0 makes it Event type.
- EdgeMask, '0 (Width bits): bit i = 1 makes Event source i rising-edge detected. Ignored for Status bits.
- CntW, 8: width of the coalescing event counter and threshold.
- TimerW, 16: width of the coalescing timer and timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- event_intr_i  in  Width  raw interrupt sources
- reg2hw_intr_enable_q_i  in  Width  INTR_ENABLE
- reg2hw_intr_test_q_i  in  Width  INTR_TEST value
- reg2hw_intr_test_qe_i  in  1  INTR_TEST write strobe
- reg2hw_intr_state_q_i  in  Width  INTR_STATE current value
- hw2reg_intr_state_de_o  out  Width  per-bit INTR_STATE write enable
- hw2reg_intr_state_d_o  out  Width  INTR_STATE next value
- cfg_coal_en_i  in  1  enables moderation
- cfg_thresh_i  in  CntW  arrival-count threshold
- cfg_timeout_i  in  TimerW  timeout in cycles; 0 disables the timer
- intr_o  out  Width  per-bit interrupt, flopped
- irq_o  out  1  moderated aggregate interrupt, flopped
- coal_cnt_o  out  CntW  current arrival count (debug)

Behaviour:
- Reset: intr_o, irq_o, coal_cnt_o, test flops, edge flops, counter, timer all 0. FSM resets to IDLE.
- test_i = {Width{qe}} & test_q.
- Edge detect: for bits with EdgeMask=1 and StatusMask=0, ev_i = event_intr_i & ~ev_q, where ev_q is the input flopped each cycle. Otherwise ev_i = event_intr_i.
- Event bit: new_i = test_i | ev_i; de_i = new_i; d_i = 1; status_i = state_q_i.
- Status bit: test_q_i loads test_q on qe; de_i = 1; d_i = status_i = event_intr_i | test_q_i.
- intr_o (registered) = status & enable, one-cycle latency.
- Pending: pend = |(status & enable).
- Arrivals: arr = popcount(status & enable & ~prev), where prev is (status & enable) from the previous cycle.
- cfg_coal_en_i = 0: irq_o (registered) = pend; FSM held in IDLE; counter and timer held at 0.
- FSM with cfg_coal_en_i = 1:
  - IDLE: if arr > 0, go to WAIT with cnt = arr (saturating) and tmr = 1. If in addition arr >= cfg_thresh_i (thresh 0 or 1 always satisfies this), go directly to FIRE.
  - WAIT: each cycle cnt += arr (saturating at 2^CntW-1) and tmr += 1 (saturating).
    - Go to FIRE if cnt_next >= cfg_thresh_i, or if cfg_timeout_i != 0 and tmr_next >= cfg_timeout_i.
    - Both conditions in the same cycle: a single FIRE.
    - If pend = 0 (SW cleared everything) and no fire condition holds: go to IDLE, cnt and tmr cleared.
  - FIRE: irq_o = 1 (asserted the cycle after entry). Stay while pend = 1; arrivals during FIRE are not counted. When pend = 0: go to IDLE, cnt and tmr cleared, irq_o = 0 the following cycle.
- Changing cfg_* mid-WAIT takes effect on the next compare; no restart.
- Dropping cfg_coal_en_i in any state: FSM forced to IDLE next cycle and irq_o follows pend.
- Reset asserted mid-operation: all state cleared asynchronously. No irq_o pulse on release.
- Enable bit cleared while pending: that bit leaves pend and intr_o next cycle; INTR_STATE is unaffected.
- coal_cnt_o = cnt.

Test Plan:
- Width=4, StatusMask=4'b0100, coalescing off: pulse event[0] one cycle, enable=4'hF -> de_o[0]=1 and d_o[0]=1 that cycle; after state_q rises, intr_o[0]=1 and irq_o=1 one cycle later.
- EdgeMask[1]=1: hold event[1] high for 5 cycles -> de_o[1]=1 only on the first cycle. Status bit 2: input high 3 cycles -> d_o[2] tracks the input, de_o[2]=1 constantly.
- Test write: qe=1, test_q=4'b0101 -> event bit 0 sets; status bit 2 asserts and stays asserted until a test write of 0.
- Coalescing on, thresh=3, timeout=0: arrivals on 3 distinct bits in separate cycles -> irq_o rises one cycle after the third arrival. SW clears all state -> irq_o falls and coal_cnt_o=0.
- thresh=10, timeout=20: single arrival -> irq_o rises exactly 20 cycles later. With thresh reached and timeout expiring in the same cycle -> single FIRE, no glitch.
- In WAIT (cnt=1, thresh=4), SW clears state -> FSM returns to IDLE, irq_o never asserts. Then assert rst_ni low mid-FIRE -> irq_o=0 and cnt=0 immediately.
